rr_channel_arbiter: RTL and testbench
=====================================

// Module: rr_channel_arbiter
// PURPOSE
//  Round-robin arbiter sharing one N-bit datapath channel between M requesters.
//  Drives the select index of the M:1 channel multiplexer and holds the grant for a full burst.
//  Releases the grant on the last beat, or on a stall timeout.
//  Sits between the requesting units (e.g. cores / DMA ports) and a single shared bus/memory port.
// PARAMETERS
//  M        4   number of requesters (1..128)
//  N        32  data bits per channel
//  TIMEOUT  16  consecutive stalled cycles before forced release; 0 = never time out
//  SEL_W    derived, not overridable: ceil(log2 M), minimum 1
// PORTS
//  clk       in   1          single clock, rising edge
//  rst       in   1          synchronous reset, active-high
//  req       in   M          req[i]=1: requester i presents a valid beat
//  req_data  in   [M][N]     packed per-requester beat data
//  req_last  in   M          req_last[i]=1: beat from i is the last of its burst
//  out_ready in   1          downstream accepts the beat this cycle
//  grant     out  M          one-hot owner of the channel; 0 when idle
//  select    out  SEL_W      index of owner; mux select
//  out_valid out  1          = req[select] while owned
//  out_data  out  N          = req_data[select] (combinational through mux)
//  busy      out  1          channel owned (state GRANT)
//  timeout   out  1          1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (rst=1 at clk edge, wins over everything):
//   state=IDLE, grant=0, select=0, ptr=0, stall_cnt=0, busy=0, timeout=0.
//   out_valid=0 and out_data=0 while not owned.
//  State IDLE:
//   - if |req: pick first i with req[i], searching ptr, ptr+1, ... mod M.
//   - Register grant=onehot(i), select=i; go GRANT.
//   - Else stay.
//  Latency: req rising in IDLE at cycle t -> grant/busy at t+1; first beat may transfer at t+1.
//  State GRANT:
//   - Beat transfers when out_valid && out_ready.
//   - Transfer with req_last[select]=1 -> ptr=(select==M-1)?0:select+1, grant=0, go IDLE.
//   - One bubble cycle between bursts is required (no same-cycle re-grant).
//   - Transfer without last -> stay; stall_cnt=0.
//   - out_valid=0 (owner paused) -> grant held; stall_cnt++.
//     out_ready=0 alone does not count toward stall_cnt (downstream backpressure).
//   - TIMEOUT>0 and stall_cnt reaches TIMEOUT-1 with out_valid still 0 -> release as on last:
//     ptr advanced, go IDLE, timeout=1 for one cycle.
//  Fairness:
//   - A requester cannot win twice while another requester holds continuous req.
//   - Worst-case wait is M-1 bursts.
//  Boundaries:
//   - M=1: select fixed 0; ptr wraps 0->0.
//   - M not a power of two: select/ptr never exceed M-1.
//   - req deasserted after grant but before first beat: treated as a pause (stall rules apply).
//   - req of non-owners is ignored during GRANT.
//   - rst mid-burst: immediate IDLE; the partial burst is abandoned (no out_valid next cycle).
//  Widths: stall_cnt is wide enough for TIMEOUT-1; it saturates and never wraps.
// STRUCTURE
//  arbiter_pkg:
//   - typedef enum logic {IDLE, GRANT} arb_state_t
//   - function sel_width(M) for SEL_W
//  Sub-module rr_priority_picker (combinational): inputs req[M], ptr[SEL_W];
//   outputs onehot[M], index[SEL_W], any. Rotating-priority search.
//  Top holds the FSM, ptr, stall_cnt and the output mux.
// TESTING
//  1. rst held 3 cycles with req=4'b1111 -> grant=0, busy=0, out_valid=0 throughout.
//  2. M=4, req=4'b1111, 1-beat bursts (last=1), ready=1 -> grant 0001,0010,0100,1000,0001
//     on alternating cycles with IDLE bubbles.
//  3. req[2] 3-beat burst, ready toggling 1,0,1,1 -> select=2 held;
//     exactly 3 transfers; release after beat 3; ptr=3.
//  4. TIMEOUT=4, owner 1 drops req after grant -> timeout pulse 4 cycles later;
//     next grant goes to the lowest pending index >=2.
//  5. ptr=3, req=4'b1001 -> grant 1000 first, then 0001 (wrap-around).
//  6. rst asserted mid-burst on owner 2 -> IDLE next cycle;
//     after rst drops, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin channel arbiter.
// Contents: arb_state_t FSM encoding, sel_width() index-width helper.
package arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Bits needed to hold values 0..m-1, never less than 1.
   function automatic int sel_width(input int m);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << w) < m) w++;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority search over M request lines.
// Ports: req (M), ptr (start index) -> onehot (M), index (SEL_W), any.
module rr_priority_picker #(
   parameter int M     = 4,
   parameter int SEL_W = 2
) (
   input  logic [M-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [M-1:0]     onehot,
   output logic [SEL_W-1:0] index,
   output logic             any
);

   logic [2*M-1:0] dbl;
   logic [M-1:0]   rot;
   logic [M-1:0]   one;
   int             s;

   // Rotate so that bit 0 of rot is requester ptr, then take the
   // first set bit and map it back to an absolute index.
   always_comb begin
      dbl    = {req, req} >> ptr;
      rot    = dbl[M-1:0];
      one    = '0;
      one[0] = 1'b1;
      any    = 1'b0;
      index  = '0;
      s      = 0;
      for (int k = 0; k < M; k++) begin
         if (!any && rot[k]) begin
            any = 1'b1;
            s   = int'(ptr) + k;
            if (s >= M) s = s - M;
            index = SEL_W'(s);
         end
      end
      onehot = any ? (one << index) : '0;
   end

endmodule

// File: rtl/rr_channel_arbiter.sv
// Round-robin owner of one shared N-bit channel among M requesters.
// Ports: clk, rst; req/req_data/req_last (per requester), out_ready in;
//        grant, select, out_valid, out_data, busy, timeout out.
module rr_channel_arbiter
   import arbiter_pkg::*;
#(
   parameter  int M       = 4,
   parameter  int N       = 32,
   parameter  int TIMEOUT = 16,
   localparam int SEL_W   = sel_width(M)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [M-1:0]        req,
   input  logic [M-1:0][N-1:0] req_data,
   input  logic [M-1:0]        req_last,
   input  logic                out_ready,
   output logic [M-1:0]        grant,
   output logic [SEL_W-1:0]    select,
   output logic                out_valid,
   output logic [N-1:0]        out_data,
   output logic                busy,
   output logic                timeout
);

   localparam int CNT_W = sel_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   arb_state_t       state_q, state_d;
   logic [M-1:0]     grant_q, grant_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             tmo_q, tmo_d;

   logic [M-1:0]     pick_oh;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             owned;
   logic             xfer;
   logic             tmo_hit;
   logic [SEL_W-1:0] nxt_ptr;

   rr_priority_picker #(
      .M     (M),
      .SEL_W (SEL_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .onehot (pick_oh),
      .index  (pick_idx),
      .any    (pick_any)
   );

   assign owned     = (state_q == GRANT);
   assign out_valid = owned & req[sel_q];
   assign out_data  = owned ? req_data[sel_q] : '0;
   assign xfer      = out_valid & out_ready;
   assign tmo_hit   = (TIMEOUT > 0) && !out_valid &&
                      (stall_q == CNT_W'(TIMEOUT - 1));
   assign nxt_ptr   = (sel_q == SEL_W'(M - 1)) ? '0 :
                      sel_q + SEL_W'(1);

   assign grant   = grant_q;
   assign select  = sel_q;
   assign busy    = owned;
   assign timeout = tmo_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      stall_d = stall_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_oh;
               sel_d   = pick_idx;
               stall_d = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (xfer) begin
               stall_d = '0;
               if (req_last[sel_q]) begin
                  ptr_d   = nxt_ptr;
                  grant_d = '0;
                  state_d = IDLE;
               end
            end else if (!out_valid) begin
               // Owner paused; backpressure alone never lands here.
               if (tmo_hit) begin
                  ptr_d   = nxt_ptr;
                  grant_d = '0;
                  stall_d = '0;
                  tmo_d   = 1'b1;
                  state_d = IDLE;
               end else if (stall_q != CNT_MAX) begin
                  stall_d = stall_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         stall_q <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         stall_q <= stall_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Scoreboard bench for rr_channel_arbiter (M=4, N=32, TIMEOUT=4).
// Expected beats are queued at drive time and checked on each transfer.
module tb_rr_channel_arbiter;

   localparam int M = 4;
   localparam int N = 32;

   logic                clk;
   logic                rst;
   logic [M-1:0]        req;
   logic [M-1:0][N-1:0] req_data;
   logic [M-1:0]        req_last;
   logic                out_ready;
   logic [M-1:0]        grant;
   logic [1:0]          select;
   logic                out_valid;
   logic [N-1:0]        out_data;
   logic                busy;
   logic                timeout;

   typedef struct {
      int          src;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_xfer   = 0;

   rr_channel_arbiter #(
      .M       (M),
      .N       (N),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .req_last  (req_last),
      .out_ready (out_ready),
      .grant     (grant),
      .select    (select),
      .out_valid (out_valid),
      .out_data  (out_data),
      .busy      (busy),
      .timeout   (timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Transfer monitor: every accepted beat must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: select=%0d data=%h, required no beat",
                     select, out_data);
         end else begin
            e = sb.pop_front();
            n_xfer++;
            if (int'(select) !== e.src || out_data !== e.data) begin
               n_fail++;
               $display("FAIL beat: select=%0d data=%h, required select=%0d data=%h",
                        select, out_data, e.src, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input logic [31:0] d);
      exp_t e;
      e.src  = s;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic set_data();
      for (int i = 0; i < M; i++) req_data[i] = 32'hA000_0000 + i;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req       = 4'b1111;
      req_last  = 4'b1111;
      out_ready = 1'b1;
      set_data();
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         n_checks++;
         if (grant !== 4'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
             out_data !== 32'h0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset c%0d: grant=%b busy=%b valid=%b data=%h tmo=%b, required all 0",
                     i, grant, busy, out_valid, out_data, timeout);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      int         x0;
      x0 = n_xfer;
      push(0, 32'hA000_0000);
      push(1, 32'hA000_0001);
      push(2, 32'hA000_0002);
      push(3, 32'hA000_0003);
      push(0, 32'hA000_0000);
      rst = 1'b0;
      for (int j = 1; j <= 9; j++) begin
         step();
         #1;
         exp_g = (j % 2 == 1) ? (4'b0001 << (((j - 1) / 2) % 4)) : 4'b0000;
         n_checks++;
         if (grant !== exp_g || busy !== (j % 2 == 1)) begin
            n_fail++;
            $display("FAIL rr c%0d: grant=%b busy=%b, required grant=%b busy=%0d",
                     j, grant, busy, exp_g, (j % 2 == 1));
         end
      end
      step();
      req      = 4'b0;
      req_last = 4'b0;
      #1;
      n_checks++;
      if (sb.size() != 0 || n_xfer - x0 != 5) begin
         n_fail++;
         $display("FAIL rr_count: transfers=%0d pending=%0d, required 5 and 0",
                  n_xfer - x0, sb.size());
      end
   endtask

   task automatic test_burst();
      bit rdy[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      int beat;
      int x0;
      x0   = n_xfer;
      beat = 0;
      push(2, 32'hB000_0000);
      push(2, 32'hB000_0001);
      push(2, 32'hB000_0002);
      req         = 4'b0100;
      req_last    = 4'b0;
      req_data[2] = 32'hB000_0000;
      out_ready   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         out_ready   = rdy[k];
         req_data[2] = 32'hB000_0000 + beat;
         req_last[2] = (beat == 2);
         #1;
         n_checks++;
         if (select !== 2'd2 || busy !== 1'b1 || grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL burst c%0d: select=%0d busy=%b grant=%b, required 2 1 0100",
                     k, select, busy, grant);
         end
         if (rdy[k]) beat++;
      end
      step();
      #1;
      n_checks++;
      if (busy !== 1'b0 || grant !== 4'b0 || n_xfer - x0 != 3) begin
         n_fail++;
         $display("FAIL burst_end: busy=%b grant=%b transfers=%0d, required 0 0000 3",
                  busy, grant, n_xfer - x0);
      end
      req       = 4'b0;
      req_last  = 4'b0;
      out_ready = 1'b1;
      set_data();
   endtask

   task automatic test_wrap();
      logic [3:0] exp_g[4] = '{4'b0000, 4'b1000, 4'b0000, 4'b0001};
      push(3, 32'hA000_0003);
      push(0, 32'hA000_0000);
      step();
      req       = 4'b1001;
      req_last  = 4'b1001;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) step();
         #1;
         n_checks++;
         if (grant !== exp_g[c]) begin
            n_fail++;
            $display("FAIL wrap c%0d: grant=%b, required %b", c, grant, exp_g[c]);
         end
      end
      step();
      req      = 4'b0;
      req_last = 4'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL wrap_end: busy=%b pending=%0d, required 0 0", busy, sb.size());
      end
   endtask

   task automatic test_timeout();
      push(3, 32'hA000_0003);
      step();
      req       = 4'b1011;
      req_last  = 4'b1000;
      out_ready = 1'b1;
      step();
      req = 4'b1001;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) step();
         #1;
         n_checks++;
         if (grant !== 4'b0010 || out_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL stall c%0d: grant=%b valid=%b tmo=%b, required 0010 0 0",
                     c, grant, out_valid, timeout);
         end
      end
      step();
      #1;
      n_checks++;
      if (timeout !== 1'b1 || busy !== 1'b0 || grant !== 4'b0) begin
         n_fail++;
         $display("FAIL tmo_pulse: tmo=%b busy=%b grant=%b, required 1 0 0000",
                  timeout, busy, grant);
      end
      step();
      #1;
      n_checks++;
      if (timeout !== 1'b0 || grant !== 4'b1000) begin
         n_fail++;
         $display("FAIL tmo_next: tmo=%b grant=%b, required 0 1000", timeout, grant);
      end
      step();
      req      = 4'b0;
      req_last = 4'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL tmo_end: busy=%b pending=%0d, required 0 0", busy, sb.size());
      end
   endtask

   task automatic test_rst_mid_burst();
      push(1, 32'hA000_0001);
      push(2, 32'hC000_0000);
      push(0, 32'hA000_0000);
      step();
      req       = 4'b0010;
      req_last  = 4'b0010;
      out_ready = 1'b1;
      step();
      #1;
      n_checks++;
      if (grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL mid_pre: grant=%b, required 0010", grant);
      end
      step();
      req         = 4'b0100;
      req_last    = 4'b0;
      req_data[2] = 32'hC000_0000;
      step();
      #1;
      n_checks++;
      if (grant !== 4'b0100 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_own: grant=%b valid=%b, required 0100 1", grant, out_valid);
      end
      step();
      rst         = 1'b1;
      out_ready   = 1'b0;
      req_data[2] = 32'hC000_0001;
      #1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_sync: busy=%b, required 1", busy);
      end
      step();
      #1;
      n_checks++;
      if (busy !== 1'b0 || grant !== 4'b0 || out_valid !== 1'b0 ||
          select !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_rst: busy=%b grant=%b valid=%b select=%0d, required 0 0000 0 0",
                  busy, grant, out_valid, select);
      end
      rst         = 1'b0;
      req         = 4'b0111;
      req_last    = 4'b0111;
      out_ready   = 1'b1;
      req_data[2] = 32'hA000_0002;
      step();
      #1;
      n_checks++;
      if (grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_restart: grant=%b, required 0001", grant);
      end
      step();
      req      = 4'b0;
      req_last = 4'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL mid_end: busy=%b pending=%0d, required 0 0", busy, sb.size());
      end
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_last  = '0;
      out_ready = 1'b0;
      req_data  = '0;
      test_reset();
      test_round_robin();
      test_burst();
      test_wrap();
      test_timeout();
      test_rst_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
